// File: rtl/conv_wb_pkg.sv
// Shared types and constants for the convolution result write-back stage.
package conv_wb_pkg;

  typedef enum logic [1:0] {
    Idle  = 2'b00,
    Read  = 2'b01,
    Drain = 2'b10,
    Done  = 2'b11
  } wb_state_e;

  // Result RAM returns data for the registered address one stage later.
  localparam int unsigned BUF_RD_LAT = 1;

endpackage

// File: rtl/conv_wb_post.sv
// Bias add, reduction to DataWidth and optional ReLU; purely combinational.
// CONV_WB_SAT_EN selects saturation instead of wrap-around for the bias add.
module conv_wb_post #(
  parameter int unsigned DataWidth = 32
) (
  input  logic [DataWidth-1:0] data_i,
  input  logic [DataWidth-1:0] bias_i,
  input  logic                 relu_en_i,
  output logic [DataWidth-1:0] result_o
);

  logic [DataWidth-1:0] reduced;

`ifdef CONV_WB_SAT_EN
  logic [DataWidth:0] sum;

  always_comb begin
    sum = {data_i[DataWidth-1], data_i} + {bias_i[DataWidth-1], bias_i};
    // Sign bits disagree only when the signed result left the DataWidth range.
    if (sum[DataWidth] != sum[DataWidth-1]) begin
      reduced = sum[DataWidth] ? {1'b1, {(DataWidth-1){1'b0}}} : {1'b0, {(DataWidth-1){1'b1}}};
    end else begin
      reduced = sum[DataWidth-1:0];
    end
  end
`else
  always_comb begin
    reduced = data_i + bias_i;
  end
`endif

  always_comb begin
    result_o = (relu_en_i && reduced[DataWidth-1]) ? '0 : reduced;
  end

endmodule

// File: rtl/conv_writeback.sv
// Streams S*S results from the result RAM, applies bias/ReLU and writes them to memory.
// Build option CONV_WB_SAT_EN (see conv_wb_post) saturates the bias add.
module conv_writeback
  import conv_wb_pkg::*;
#(
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned MaxAddrWidth = 32,
  parameter int unsigned MaxPictWidth = 9,
  parameter int unsigned MaxPixelNum  = 18,
  parameter int unsigned BufAddrWidth = 10
) (
  input  logic                    Clk0,
  input  logic                    Rst,
  input  logic                    start_in,
  input  logic [MaxPictWidth-1:0] out_size_in,
  input  logic [MaxAddrWidth-1:0] out_base_addr_in,
  input  logic [DataWidth-1:0]    bias_in,
  input  logic                    relu_en_in,
  output logic [BufAddrWidth-1:0] buf_rd_addr_out,
  input  logic [DataWidth-1:0]    buf_rd_data_in,
  output logic [MaxAddrWidth-1:0] mem_wr_addr_out,
  output logic [DataWidth-1:0]    mem_wr_data_out,
  output logic                    mem_wr_en_out,
  input  logic                    mem_wr_ready_in,
  output logic                    busy_out,
  output logic                    done_out
);

  wb_state_e state_q, state_d;

  logic [MaxPixelNum-1:0]  size_ext, n_q, rd_idx_q, p1_idx_q;
  logic [MaxAddrWidth-1:0] base_q, wr_addr_q;
  logic [DataWidth-1:0]    bias_q, p1_data_q, wr_data_q, post_res;
  logic                    relu_q, p0_vld_q, p1_vld_q, wr_en_q;
  logic                    launch, stall, wr_accept, last_rd;

  assign size_ext  = MaxPixelNum'(out_size_in);
  assign launch    = (state_q == Idle) && start_in;
  assign stall     = wr_en_q && !mem_wr_ready_in;
  assign wr_accept = wr_en_q && mem_wr_ready_in;
  assign last_rd   = (rd_idx_q == n_q - MaxPixelNum'(1));

  conv_wb_post #(
    .DataWidth(DataWidth)
  ) u_post (
    .data_i   (p1_data_q),
    .bias_i   (bias_q),
    .relu_en_i(relu_q),
    .result_o (post_res)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      Idle:  if (launch) state_d = (out_size_in == '0) ? Done : Read;
      Read:  if (!stall && last_rd) state_d = Drain;
      // p1 empty means the word being accepted is the final one.
      Drain: if (wr_accept && !p1_vld_q) state_d = Done;
      Done:  state_d = Idle;
    endcase
  end

  always_ff @(posedge Clk0) begin
    if (Rst) begin
      state_q   <= Idle;
      n_q       <= '0;
      base_q    <= '0;
      bias_q    <= '0;
      relu_q    <= 1'b0;
      rd_idx_q  <= '0;
      p0_vld_q  <= 1'b0;
      p1_vld_q  <= 1'b0;
      p1_idx_q  <= '0;
      p1_data_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (launch) begin
        n_q      <= size_ext * size_ext;
        base_q   <= out_base_addr_in;
        bias_q   <= bias_in;
        relu_q   <= relu_en_in;
        rd_idx_q <= '0;
        p0_vld_q <= (out_size_in != '0);
      end else if (!stall) begin
        if (p0_vld_q) begin
          if (last_rd) p0_vld_q <= 1'b0;
          else         rd_idx_q <= rd_idx_q + MaxPixelNum'(1);
        end
        p1_vld_q  <= p0_vld_q;
        p1_idx_q  <= rd_idx_q;
        p1_data_q <= buf_rd_data_in;
        wr_en_q   <= p1_vld_q;
        if (p1_vld_q) begin
          wr_addr_q <= base_q + MaxAddrWidth'(p1_idx_q);
          wr_data_q <= post_res;
        end
      end
    end
  end

  assign buf_rd_addr_out = rd_idx_q[BufAddrWidth-1:0];
  assign mem_wr_addr_out = wr_addr_q;
  assign mem_wr_data_out = wr_data_q;
  assign mem_wr_en_out   = wr_en_q;
  assign busy_out        = (state_q != Idle);
  assign done_out        = (state_q == Done);

endmodule
